// File: rtl/hazard_controller_if.sv
// Hazard controller bus: decode-stage inputs and stage-3 mux selects.
//   master : pipeline side, drives ir2_output/branch_taken/ex_stall,
//            consumes the selects, fetch_stall and stall_count.
//   slave  : hazard controller side.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ir2_output;
    logic             branch_taken;
    logic             ex_stall;
    logic [1:0]       select_ir3;
    logic             select_pc3;
    logic [1:0]       select_x3;
    logic [1:0]       select_y3;
    logic [1:0]       select_md3;
    logic             fetch_stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ir2_output, branch_taken, ex_stall,
        input  select_ir3, select_pc3, select_x3, select_y3, select_md3,
               fetch_stall, stall_count
    );

    modport slave (
        input  ir2_output, branch_taken, ex_stall,
        output select_ir3, select_pc3, select_x3, select_y3, select_md3,
               fetch_stall, stall_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage core.
// Keeps a scoreboard of destination registers in stages 3/4/5 and, from it
// and the decode-stage instruction, chooses per cycle: issue (with optional
// forwarding from z5), nop injection for data hazards or branch flush, or a
// full hold while the back end stalls.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_controller_if.slave (ir2_output, branch_taken, ex_stall
//                in; select_ir3/pc3/x3/y3/md3, fetch_stall, stall_count out)
module hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_controller_if.slave  bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH, HOLD} state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } sb_entry_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    sb_entry_t        sb3_q, sb4_q, sb5_q, sb3_d, sb4_d, sb5_d;

    // Decode
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_auipc, is_lui;
    logic       use_rs1, use_rs2, writes_rd;

    assign opcode = bus.ir2_output[6:0];
    assign rd     = bus.ir2_output[11:7];
    assign rs1    = bus.ir2_output[19:15];
    assign rs2    = bus.ir2_output[24:20];

    assign is_r      = (opcode == OP_R);
    assign is_ialu   = (opcode == OP_IALU);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_lui    = (opcode == OP_LUI);

    // x0 reads are masked here so they never match the scoreboard
    assign use_rs1   = (is_r | is_ialu | is_load | is_store | is_branch) && (rs1 != 5'd0);
    assign use_rs2   = (is_r | is_store | is_branch) && (rs2 != 5'd0);
    assign writes_rd = is_r | is_ialu | is_load | is_jal | is_auipc | is_lui;

    // Hazard / forward detection
    logic haz, fwd1, fwd2;
    assign haz  = (use_rs1 && ((sb3_q.vld && sb3_q.rd == rs1) || (sb4_q.vld && sb4_q.rd == rs1)))
               || (use_rs2 && ((sb3_q.vld && sb3_q.rd == rs2) || (sb4_q.vld && sb4_q.rd == rs2)));
    assign fwd1 = use_rs1 && sb5_q.vld && (sb5_q.rd == rs1);
    assign fwd2 = use_rs2 && sb5_q.vld && (sb5_q.rd == rs2);

    // A nonzero counter only exists while flushing or held mid-flush; it
    // survives HOLD so the flush resumes after the back end releases.
    logic flush_pend;
    assign flush_pend = ((state_q == FLUSH) || (state_q == HOLD)) && (flush_cnt_q != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 2'd0;
            stall_cnt_q <= '0;
            sb3_q       <= '0;
            sb4_q       <= '0;
            sb5_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            sb3_q       <= sb3_d;
            sb4_q       <= sb4_d;
            sb5_q       <= sb5_d;
        end
    end

    always_comb begin
        state_d         = RUN;
        flush_cnt_d     = flush_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        sb3_d           = sb3_q;
        sb4_d           = sb4_q;
        sb5_d           = sb5_q;
        bus.select_ir3  = 2'd0;
        bus.select_pc3  = 1'b0;
        bus.select_x3   = (is_jal | is_auipc) ? 2'd1 : 2'd0;
        bus.select_y3   = (is_ialu | is_load | is_store | is_lui | is_auipc | is_jal) ? 2'd1 : 2'd0;
        bus.select_md3  = 2'd0;
        bus.fetch_stall = 1'b0;

        if (reset) begin
            bus.select_ir3 = 2'd1;
            bus.select_x3  = 2'd0;
            bus.select_y3  = 2'd0;
        end else if (bus.ex_stall) begin
            // Everything frozen: scoreboard and flush counter keep their values
            state_d         = HOLD;
            bus.select_ir3  = 2'd2;
            bus.select_pc3  = 1'b1;
            bus.select_x3   = 2'd2;
            bus.select_y3   = 2'd2;
            bus.select_md3  = 2'd2;
            bus.fetch_stall = 1'b1;
        end else begin
            sb5_d = sb4_q;
            sb4_d = sb3_q;
            sb3_d = '0;
            if (bus.branch_taken || flush_pend) begin
                // ir2 is on the wrong path, so any hazard it carries is moot
                flush_cnt_d    = bus.branch_taken ? FLUSH_LOAD : flush_cnt_q - 2'd1;
                state_d        = (flush_cnt_d != 2'd0) ? FLUSH : RUN;
                bus.select_ir3 = 2'd1;
                bus.select_x3  = 2'd0;
                bus.select_y3  = 2'd0;
            end else if (haz) begin
                state_d         = STALL;
                bus.select_ir3  = 2'd1;
                bus.select_x3   = 2'd0;
                bus.select_y3   = 2'd0;
                bus.fetch_stall = 1'b1;
                if (stall_cnt_q != '1)
                    stall_cnt_d = stall_cnt_q + 1'b1;
            end else begin
                sb3_d.vld = writes_rd && (rd != 5'd0);
                sb3_d.rd  = rd;
                if (fwd1)
                    bus.select_x3 = 2'd3;
                if (fwd2 && (is_r || is_branch))
                    bus.select_y3 = 2'd3;
                if (fwd2 && is_store)
                    bus.select_md3 = 2'd1;
            end
        end
    end

    assign bus.stall_count = stall_cnt_q;
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline control unit for the 5-stage core. It drives the decode-stage mux selects: select_ir3, select_pc3, select_x3, select_y3 and select_md3.
- It keeps a registered scoreboard of destination registers in stages 3/4/5. From that scoreboard and ir2 it decides, each cycle, whether to pass, forward from z5, inject a nop, flush or hold.
- It also freezes fetch/ir2 on data stalls and counts stall cycles.

Parameters:
- FLUSH_CYCLES, 2, cycles of nop injection into ir3 per taken branch, including the resolve cycle (range 1-3).
- CNT_W, 16, width of the stall_count performance counter.

Ports:
- clk  input  1  clock. Single clock domain; reset is synchronous, active-high.
- reset  input  1  synchronous active-high reset.
- ir2_output  input  32  instruction in decode. Fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- branch_taken  input  1  branch/jump resolved taken this cycle.
- ex_stall  input  1  back-end stall; whole stage 3+ boundary must hold.
- select_ir3  output  2  0 pass ir2, 1 nop, 2 hold.
- select_pc3  output  1  0 pass pc2, 1 hold.
- select_x3  output  2  0 r1_value, 1 pc2_output, 2 hold, 3 z5_output.
- select_y3  output  2  0 r2_value, 1 sextended_value, 2 hold, 3 z5_output.
- select_md3  output  2  0 r2_value, 1 z5_output, 2 hold.
- fetch_stall  output  1  hold pc1/ir2 registers.
- stall_count  output  CNT_W  saturating count of cycles with nop injected for data hazards.

Behaviour:
- Decode classes (combinational, from opcode):
  - R 0110011: uses rs1+rs2, writes rd.
  - I-ALU 0010011: rs1, writes rd.
  - LOAD 0000011: rs1, writes rd.
  - STORE 0100011: rs1, rs2-as-data.
  - BRANCH 1100011: rs1+rs2.
  - JAL 1101111: writes rd, x=pc.
  - AUIPC 0010111: x=pc, writes rd.
  - LUI 0110111: writes rd.
  - Any other opcode: uses and writes nothing.
  - Register 0 never creates a hazard and never enters the scoreboard.
- Operand source selection:
  - Default selects: x3=0, except 1 for JAL/AUIPC.
  - y3=1 for I-ALU/LOAD/STORE/LUI/AUIPC/JAL; y3=0 for R/BRANCH.
  - md3=0.
- Scoreboard: three registered entries (valid, rd[4:0]) for stages 3, 4, 5.
  - On an advancing cycle (ex_stall=0): s5<=s4, s4<=s3.
  - s3 <= {writes_rd && rd!=0, rd} when ir2 issues; s3 <= invalid when a nop is injected.
  - While ex_stall=1, the scoreboard is frozen.
- FSM states: RUN, STALL, FLUSH, HOLD. Priority each cycle: reset > ex_stall > branch_taken/flush > data hazard > normal issue.
- HOLD (ex_stall=1):
  - select_ir3=2, pc3=1, x3=2, y3=2, md3=2, fetch_stall=1.
  - The flush counter is frozen.
  - On leaving HOLD, re-evaluate using the priority order.
- FLUSH:
  - branch_taken=1 loads the flush counter with FLUSH_CYCLES-1 and injects a nop this cycle.
  - While the counter is nonzero, inject a nop and decrement.
  - Nop injection means: select_ir3=1, x3=0, y3=0, md3=0, pc3=0, fetch_stall=0.
  - branch_taken during FLUSH reloads the counter.
  - A data hazard during FLUSH is ignored, because the ir2 instruction is discarded.
- Data hazard:
  - Condition: a used source register matches a valid s3 or s4 entry.
  - Response: inject a nop, fetch_stall=1, increment stall_count (saturates at all-ones). Stay in STALL until the condition clears; re-evaluate every cycle.
  - No forwarding from stages 3/4. A load-use hazard is handled identically.
- Forwarding from s5 (no stall): on a match with valid s5,
  - rs1 forwards via x3=3;
  - rs2 as ALU operand (R/BRANCH) forwards via y3=3;
  - STORE rs2 forwards via md3=1.
- Reset:
  - Scoreboard invalid, flush counter 0, state RUN, stall_count 0.
  - While reset=1, outputs are: select_ir3=1, pc3=0, x3=0, y3=0, md3=0, fetch_stall=0.
  - Reset asserted mid-flush or mid-stall aborts the flush or stall immediately.
- Output timing: selects are combinational from registered state and ir2_output. There is zero-cycle latency to the stage-3 input muxes.

Test Plan:
- addi x5,x0,1 (0x00100293) then add x6,x5,x5 (0x00528333):
  - 2 cycles of select_ir3=1 with fetch_stall=1;
  - 3rd cycle select_ir3=0, x3=3, y3=3;
  - stall_count=2.
- x5 in s5 only (two unrelated instructions between), then sw x5,0(x2) (0x00512023) -> no stall; x3=0, y3=1, md3=1.
- branch_taken pulse with FLUSH_CYCLES=2 while a hazardous add sits in ir2 -> select_ir3=1 for exactly 2 cycles; fetch_stall=0; stall_count unchanged.
- ex_stall held 3 cycles during a STALL:
  - all selects = hold, fetch_stall=1;
  - scoreboard frozen, so stall resumes with the same remaining count after release.
- Instruction with rd=x0 (addi x0,x0,0) followed by add reading x0 -> no stall, no forwarding.
- reset asserted during FLUSH:
  - next cycle state RUN, counter 0, stall_count 0;
  - first post-reset instruction passes with select_ir3=0.
